// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg
// Shared definitions for the memory request arbiter:
//   owner_e    - encoding of the master that issued a request (stored in the owner FIFO)
//   SIZE_*     - SRAM-like transfer size encodings carried on *_size
//   mem_cmd_t  - bundle of the request fields muxed onto the downstream port
package mem_req_arbiter_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// owner_fifo
// Small synchronous FIFO recording which master owns each issued request.
// Ports:
//   clk, resetn       - clock, asynchronous active-low reset
//   push, push_data   - enqueue (ignored when full)
//   pop               - dequeue (ignored when empty)
//   head              - entry at the read pointer
//   full, empty       - occupancy flags
//   count             - number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module owner_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Merges the fetch (inst_*) and execute (data_*) SRAM-like ports onto one
// downstream port (mem_*). Data has fixed priority over inst; once a request
// is presented without mem_addr_ok the grant locks to that master until it is
// accepted or withdrawn. An owner FIFO routes each in-order mem_data_ok back
// to the master that issued the request.
// Ports:
//   clk, resetn                      - clock, asynchronous active-low reset
//   inst_req/wr/size/addr/wstrb/wdata - fetch request in
//   inst_addr_ok/data_ok/rdata       - fetch handshake/response out
//   data_req/wr/size/addr/wstrb/wdata - execute request in
//   data_addr_ok/data_ok/rdata       - execute handshake/response out
//   mem_req/wr/size/addr/wstrb/wdata  - downstream request out
//   mem_addr_ok/data_ok/rdata        - downstream handshake/response in
//   busy                             - requests outstanding
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam int unsigned CW = $clog2(OUTSTANDING) + 1;

    logic        lock_valid;
    logic        lock_valid_next;
    owner_e      lock_owner;
    owner_e      lock_owner_next;

    owner_e      sel_owner;
    logic        sel_valid;

    mem_cmd_t    inst_cmd;
    mem_cmd_t    data_cmd;
    mem_cmd_t    mem_cmd;

    logic        fifo_push;
    logic        fifo_pop;
    logic [0:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;

    assign inst_cmd = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                        wstrb: inst_wstrb, wdata: inst_wdata};
    assign data_cmd = '{wr: data_wr, size: data_size, addr: data_addr,
                        wstrb: data_wstrb, wdata: data_wdata};

    // Selection looks only at the requests and the lock, never at
    // mem_addr_ok, so there is no combinational path mem_addr_ok -> mem_req.
    // sel_valid is the selected master's req: a locked master that drops req
    // leaves the port idle for one cycle while the lock clears.
    always_comb begin
        sel_owner = OWNER_INST;
        if (lock_valid) begin
            sel_owner = lock_owner;
        end else if (data_req) begin
            sel_owner = OWNER_DATA;
        end
        sel_valid = (sel_owner == OWNER_DATA) ? data_req : inst_req;
    end

    always_comb begin
        mem_cmd = '0;
        if (sel_valid) begin
            mem_cmd = (sel_owner == OWNER_DATA) ? data_cmd : inst_cmd;
        end
    end

    assign mem_req   = sel_valid & ~fifo_full;
    assign mem_wr    = mem_cmd.wr;
    assign mem_size  = mem_cmd.size;
    assign mem_addr  = mem_cmd.addr;
    assign mem_wstrb = mem_cmd.wstrb;
    assign mem_wdata = mem_cmd.wdata;

    assign inst_addr_ok = mem_addr_ok & mem_req & (sel_owner == OWNER_INST);
    assign data_addr_ok = mem_addr_ok & mem_req & (sel_owner == OWNER_DATA);

    // A presented-but-not-accepted request holds the grant; acceptance or a
    // withdrawn req (mem_req low) both fall out as lock_valid_next = 0.
    always_comb begin
        lock_valid_next = mem_req & ~mem_addr_ok;
        lock_owner_next = lock_owner;
        if (lock_valid_next) begin
            lock_owner_next = sel_owner;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_owner <= OWNER_INST;
        end else begin
            lock_valid <= lock_valid_next;
            lock_owner <= lock_owner_next;
        end
    end

    assign fifo_push = mem_req & mem_addr_ok;
    assign fifo_pop  = mem_data_ok;

    owner_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_owner_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (1'(sel_owner)),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A stray mem_data_ok with nothing outstanding is not routed anywhere.
    assign inst_data_ok = mem_data_ok & ~fifo_empty & (fifo_head == 1'(OWNER_INST));
    assign data_data_ok = mem_data_ok & ~fifo_empty & (fifo_head == 1'(OWNER_DATA));

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    assign busy = ~fifo_empty;

    a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        !(mem_data_ok && fifo_empty));

    a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
        fifo_count <= CW'(OUTSTANDING));

    a_size_legal: assert property (@(posedge clk) disable iff (!resetn)
        mem_req |-> (mem_size == SIZE_BYTE || mem_size == SIZE_HALF || mem_size == SIZE_WORD));

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_req_arbiter #(.OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic idle();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        resetn = 0; idle();
        @(negedge clk); #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
        n_checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin n_fail++; $display("FAIL reset_handshakes: got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr_idle: got %08h want 00000000", mem_addr); end
        inst_req = 1; inst_addr = 32'h1C00_0000; #1;
        n_checks++; if (mem_addr !== 32'h1C00_0000) begin n_fail++; $display("FAIL reset_mux_follow: got %08h want 1c000000", mem_addr); end
        @(negedge clk); idle(); resetn = 1;
    endtask

    task automatic test_single_inst_read();
        @(negedge clk); idle();
        inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2'd2; mem_addr_ok = 1; #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL single_mem_req: got %0h want 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h1C00_0000) begin n_fail++; $display("FAIL single_mem_addr: got %08h want 1c000000", mem_addr); end
        n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL single_addr_ok: got %b want 10", {inst_addr_ok, data_addr_ok}); end
        @(negedge clk); idle(); #1;
        n_checks++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL single_addr_ok_pulse: got %0h want 0", inst_addr_ok); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0h want 1", busy); end
        @(negedge clk); idle(); mem_data_ok = 1; mem_rdata = 32'h0280_0000; #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL single_data_ok: got %b want 10", {inst_data_ok, data_data_ok}); end
        n_checks++; if (inst_rdata !== 32'h0280_0000) begin n_fail++; $display("FAIL single_rdata: got %08h want 02800000", inst_rdata); end
        @(negedge clk); idle(); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %0h want 0", busy); end
    endtask

    task automatic test_collision();
        @(negedge clk); idle();
        inst_req = 1; inst_addr = 32'h1C00_0100;
        data_req = 1; data_addr = 32'h0000_1000; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
        mem_addr_ok = 1; #1;
        n_checks++; if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL coll_first_addr: got %08h want 00001000", mem_addr); end
        n_checks++; if ({mem_wr, mem_wstrb, mem_wdata} !== {1'b1, 4'hF, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL coll_first_wfields: got %0h/%0h/%08h want 1/f/deadbeef", mem_wr, mem_wstrb, mem_wdata); end
        n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin n_fail++; $display("FAIL coll_first_addr_ok: got %b want 01", {inst_addr_ok, data_addr_ok}); end
        @(negedge clk); idle();
        inst_req = 1; inst_addr = 32'h1C00_0100; mem_addr_ok = 1; #1;
        n_checks++; if (mem_addr !== 32'h1C00_0100) begin n_fail++; $display("FAIL coll_second_addr: got %08h want 1c000100", mem_addr); end
        n_checks++; if ({mem_wr, inst_addr_ok, data_addr_ok} !== 3'b010) begin n_fail++; $display("FAIL coll_second_addr_ok: got %b want 010", {mem_wr, inst_addr_ok, data_addr_ok}); end
        @(negedge clk); idle(); mem_data_ok = 1; mem_rdata = 32'h1111_1111; #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL coll_resp_d: got %b want 01", {inst_data_ok, data_data_ok}); end
        n_checks++; if (data_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL coll_resp_d_rdata: got %08h want 11111111", data_rdata); end
        @(negedge clk); idle(); mem_data_ok = 1; mem_rdata = 32'h2222_2222; #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL coll_resp_i: got %b want 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk); idle(); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL coll_busy_end: got %0h want 0", busy); end
    endtask

    task automatic test_lock();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); idle();
            inst_req = 1; inst_addr = 32'h1C00_0200;
            if (c >= 1) begin data_req = 1; data_addr = 32'h0000_2000; end
            #1;
            n_checks++; if (mem_addr !== 32'h1C00_0200) begin n_fail++; $display("FAIL lock_hold_addr_c%0d: got %08h want 1c000200", c, mem_addr); end
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL lock_hold_req_c%0d: got %0h want 1", c, mem_req); end
        end
        @(negedge clk); idle();
        inst_req = 1; inst_addr = 32'h1C00_0200; data_req = 1; data_addr = 32'h0000_2000; mem_addr_ok = 1; #1;
        n_checks++; if (mem_addr !== 32'h1C00_0200) begin n_fail++; $display("FAIL lock_accept_addr: got %08h want 1c000200", mem_addr); end
        n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_accept_addr_ok: got %b want 10", {inst_addr_ok, data_addr_ok}); end
        @(negedge clk); idle();
        data_req = 1; data_addr = 32'h0000_2000; mem_addr_ok = 1; #1;
        n_checks++; if (mem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL lock_then_data_addr: got %08h want 00002000", mem_addr); end
        n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin n_fail++; $display("FAIL lock_then_data_addr_ok: got %b want 01", {inst_addr_ok, data_addr_ok}); end
        @(negedge clk); idle(); mem_data_ok = 1; #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_resp_i: got %b want 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk); idle(); mem_data_ok = 1; #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL lock_resp_d: got %b want 01", {inst_data_ok, data_data_ok}); end
        @(negedge clk); idle();
    endtask

    task automatic test_flush();
        @(negedge clk); idle();
        inst_req = 1; inst_addr = 32'h1C00_6000; #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_lock_req: got %0h want 1", mem_req); end
        @(negedge clk); idle();
        data_req = 1; data_addr = 32'h0000_5000; mem_addr_ok = 1; #1;
        n_checks++; if ({mem_req, data_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL flush_dropped_cycle: got %b want 00", {mem_req, data_addr_ok}); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL flush_mux_zero: got %08h want 00000000", mem_addr); end
        @(negedge clk); idle();
        data_req = 1; data_addr = 32'h0000_5000; mem_addr_ok = 1; #1;
        n_checks++; if ({mem_req, data_addr_ok} !== 2'b11) begin n_fail++; $display("FAIL flush_regrant: got %b want 11", {mem_req, data_addr_ok}); end
        n_checks++; if (mem_addr !== 32'h0000_5000) begin n_fail++; $display("FAIL flush_regrant_addr: got %08h want 00005000", mem_addr); end
        @(negedge clk); idle(); mem_data_ok = 1; #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL flush_resp: got %b want 01", {inst_data_ok, data_data_ok}); end
        @(negedge clk); idle(); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_end: got %0h want 0", busy); end
    endtask

    task automatic test_full_fifo();
        @(negedge clk); idle(); inst_req = 1; inst_addr = 32'h1C00_3000; mem_addr_ok = 1;
        @(negedge clk); idle(); data_req = 1; data_addr = 32'h0000_3000; mem_addr_ok = 1; #1;
        n_checks++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_second_accept: got %0h want 1", data_addr_ok); end
        @(negedge clk); idle(); inst_req = 1; inst_addr = 32'h1C00_3004; mem_addr_ok = 1; #1;
        n_checks++; if ({mem_req, inst_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL full_blocked: got %b want 00", {mem_req, inst_addr_ok}); end
        @(negedge clk); mem_data_ok = 1; #1;
        n_checks++; if ({mem_req, inst_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL full_pop_cycle_blocked: got %b want 00", {mem_req, inst_addr_ok}); end
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL full_pop_route: got %b want 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk); mem_data_ok = 0; #1;
        n_checks++; if ({mem_req, inst_addr_ok} !== 2'b11) begin n_fail++; $display("FAIL full_third_issue: got %b want 11", {mem_req, inst_addr_ok}); end
        n_checks++; if (mem_addr !== 32'h1C00_3004) begin n_fail++; $display("FAIL full_third_addr: got %08h want 1c003004", mem_addr); end
        @(negedge clk); idle(); mem_data_ok = 1; #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL full_drain_d: got %b want 01", {inst_data_ok, data_data_ok}); end
        @(negedge clk); idle(); mem_data_ok = 1; #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL full_drain_i: got %b want 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk); idle(); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %0h want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_aok, exp_dok;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk); idle();
            if (k < 10) begin
                if (k % 2 == 0) begin inst_req = 1; inst_addr = 32'h1C00_1000 + 32'(k * 4); end
                else begin data_req = 1; data_addr = 32'h0000_4000 + 32'(k * 4); end
                mem_addr_ok = 1;
            end
            if (k >= 1) begin mem_data_ok = 1; mem_rdata = 32'hA000_0000 + 32'(k); end
            #1;
            exp_aok = (k >= 10) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
            exp_dok = (k == 0)  ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b10 : 2'b01);
            n_checks++; if ({inst_addr_ok, data_addr_ok} !== exp_aok) begin n_fail++; $display("FAIL b2b_addr_ok_k%0d: got %b want %b", k, {inst_addr_ok, data_addr_ok}, exp_aok); end
            n_checks++; if ({inst_data_ok, data_data_ok} !== exp_dok) begin n_fail++; $display("FAIL b2b_data_ok_k%0d: got %b want %b", k, {inst_data_ok, data_data_ok}, exp_dok); end
            if (k >= 1) begin
                n_checks++; if (data_rdata !== 32'hA000_0000 + 32'(k)) begin n_fail++; $display("FAIL b2b_rdata_k%0d: got %08h want %08h", k, data_rdata, 32'hA000_0000 + 32'(k)); end
            end
        end
        @(negedge clk); idle(); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %0h want 0", busy); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); idle(); inst_req = 1; inst_addr = 32'h1C00_5000; mem_addr_ok = 1;
        @(negedge clk); idle(); data_req = 1; data_addr = 32'h0000_6000; mem_addr_ok = 1;
        @(negedge clk); idle(); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL areset_busy_before: got %0h want 1", busy); end
        @(posedge clk); #2; resetn = 0; #1;
        n_checks++; if ({busy, mem_req} !== 2'b00) begin n_fail++; $display("FAIL areset_cleared: got %b want 00", {busy, mem_req}); end
        @(negedge clk); resetn = 1;
        // lock to inst, then reset mid-cycle while data also requests
        @(negedge clk); idle(); inst_req = 1; inst_addr = 32'h1C00_7000;
        @(posedge clk); #2; data_req = 1; data_addr = 32'h0000_7000; #1;
        n_checks++; if (mem_addr !== 32'h1C00_7000) begin n_fail++; $display("FAIL areset_locked_addr: got %08h want 1c007000", mem_addr); end
        resetn = 0; #1;
        n_checks++; if (mem_addr !== 32'h0000_7000) begin n_fail++; $display("FAIL areset_lock_cleared: got %08h want 00007000", mem_addr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy_locked: got %0h want 0", busy); end
        @(negedge clk); resetn = 1; mem_addr_ok = 1; #1;
        n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin n_fail++; $display("FAIL areset_post_grant: got %b want 01", {inst_addr_ok, data_addr_ok}); end
        @(negedge clk); idle(); mem_data_ok = 1; #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL areset_post_resp: got %b want 01", {inst_data_ok, data_data_ok}); end
        @(negedge clk); idle(); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy_end: got %0h want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_inst_read();
        test_collision();
        test_lock();
        test_flush();
        test_full_fifo();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
